// File: rtl/vfd_pkg.sv
// Shared constants and FSM encoding for the MN15439A grid refresh path.
package vfd_pkg;

  localparam int GRID_COUNT_MN15439A = 52;
  localparam int BITS_PER_GRID       = 288;
  localparam int GRID_PERIOD_12M     = 3840;
  localparam int GN_W                = 6;
  localparam int PERIOD_CNT_W        = 12;
  localparam int SKIP_W              = 8;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_BLANK = 3'd1,
    ST_LATCH = 3'd2,
    ST_TAIL  = 3'd3,
    ST_SHIFT = 3'd4,
    ST_WAIT  = 3'd5
  } grid_seq_state_t;

endpackage

// File: rtl/vfd_period_timer.sv
// Grid period counter: runs 0..GRID_PERIOD-1 while enabled, parked at 0 otherwise.
module vfd_period_timer
  import vfd_pkg::*;
#(
  parameter int GRID_PERIOD = GRID_PERIOD_12M,
  parameter int CNT_W       = PERIOD_CNT_W
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             run,
  output logic             tick,
  output logic [CNT_W-1:0] cnt
);

  localparam logic [CNT_W-1:0] LAST = CNT_W'(GRID_PERIOD - 1);

  assign tick = (cnt == LAST);

  always_ff @(posedge CLK) begin
    if (RST || !run) begin
      cnt <= '0;
    end else if (tick) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/vfd_grid_sequencer.sv
// Per-grid refresh sequencer: BLK/LAT pulses, grid number and the SCE shift window,
// with whole periods skipped while the host is writing GRAM.
module vfd_grid_sequencer
  import vfd_pkg::*;
#(
  parameter int GRID_COUNT    = GRID_COUNT_MN15439A,
  parameter int GRID_PERIOD   = GRID_PERIOD_12M,
  parameter int LAT_WIDTH     = 5,
  parameter int BLK_TAIL      = 1,
  parameter int BITS_PER_GRID = vfd_pkg::BITS_PER_GRID
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              EN,
  input  logic              HOST_BUSY,
  output logic [GN_W-1:0]   GN,
  output logic              BLK,
  output logic              LAT,
  output logic              SCE,
  output logic              FRAME_SYNC,
  output logic [SKIP_W-1:0] SKIP_CNT
);

  if (GRID_PERIOD < 1 + LAT_WIDTH + BLK_TAIL + BITS_PER_GRID + 1) begin : g_period_check
    $error("vfd_grid_sequencer: GRID_PERIOD too short for one grid transfer");
  end
  if (LAT_WIDTH < 1 || BLK_TAIL < 1) begin : g_width_check
    $error("vfd_grid_sequencer: LAT_WIDTH and BLK_TAIL must be at least 1");
  end

  // Phase boundaries are positions of the period counter, which is 0 on entry to BLANK.
  localparam logic [PERIOD_CNT_W-1:0] LATCH_END = PERIOD_CNT_W'(LAT_WIDTH);
  localparam logic [PERIOD_CNT_W-1:0] TAIL_END  = PERIOD_CNT_W'(LAT_WIDTH + BLK_TAIL);
  localparam logic [PERIOD_CNT_W-1:0] SHIFT_END = PERIOD_CNT_W'(LAT_WIDTH + BLK_TAIL + BITS_PER_GRID);

  grid_seq_state_t          state;
  grid_seq_state_t          next_state;
  logic [PERIOD_CNT_W-1:0]  cnt;
  logic                     tick;
  logic                     period_start;
  logic                     gn_advance;
  logic [GN_W-1:0]          gn_next;

  vfd_period_timer #(
    .GRID_PERIOD (GRID_PERIOD),
    .CNT_W       (PERIOD_CNT_W)
  ) u_timer (
    .CLK  (CLK),
    .RST  (RST),
    .run  (state != ST_IDLE),
    .tick (tick),
    .cnt  (cnt)
  );

  always_comb begin
    period_start = 1'b0;
    next_state   = state;
    case (state)
      ST_IDLE:  period_start = EN;
      ST_BLANK: next_state = ST_LATCH;
      ST_LATCH: if (cnt == LATCH_END) next_state = ST_TAIL;
      ST_TAIL:  if (cnt == TAIL_END) next_state = ST_SHIFT;
      ST_SHIFT: if (cnt == SHIFT_END) next_state = ST_WAIT;
      ST_WAIT: begin
        if (tick) begin
          if (EN) period_start = 1'b1;
          else    next_state   = ST_IDLE;
        end
      end
      default:  next_state = ST_IDLE;
    endcase
    // A busy host turns the whole period into a silent wait.
    if (period_start) next_state = HOST_BUSY ? ST_WAIT : ST_BLANK;
  end

  assign gn_advance = (state == ST_TAIL) && (next_state == ST_SHIFT);
  assign gn_next    = (GN == GN_W'(GRID_COUNT) || GN == '0) ? GN_W'(1) : GN + 1'b1;

  // Outputs are registered from next_state so they line up with the state they describe.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state      <= ST_IDLE;
      GN         <= '0;
      BLK        <= 1'b0;
      LAT        <= 1'b0;
      SCE        <= 1'b0;
      FRAME_SYNC <= 1'b0;
      SKIP_CNT   <= '0;
    end else begin
      state      <= next_state;
      BLK        <= (next_state == ST_BLANK) || (next_state == ST_LATCH) || (next_state == ST_TAIL);
      LAT        <= (next_state == ST_LATCH);
      SCE        <= (next_state == ST_SHIFT);
      FRAME_SYNC <= gn_advance && (gn_next == GN_W'(1));
      if (gn_advance) GN <= gn_next;
      if (period_start && HOST_BUSY && SKIP_CNT != '1) SKIP_CNT <= SKIP_CNT + 1'b1;
    end
  end

endmodule

// File: tb/tb_vfd_grid_sequencer.sv
// Self-checking bench for vfd_grid_sequencer against a period-offset reference model.
`timescale 1ns/1ps
module tb_vfd_grid_sequencer;

  localparam int GP  = 400;
  localparam int GC  = 4;
  localparam int LW  = 5;
  localparam int BT  = 1;
  localparam int BPG = 288;
  localparam int SHIFT_OFS = LW + BT + 1;
  localparam int SGP = 16;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       en = 1'b0;
  logic       busy = 1'b0;
  logic [5:0] gn;
  logic       blk, lat, sce, fs;
  logic [7:0] skip_cnt;

  logic       s_en = 1'b0;
  logic       s_busy = 1'b0;
  logic [5:0] s_gn;
  logic       s_blk, s_lat, s_sce, s_fs;
  logic [7:0] s_skip_cnt;

  int total = 0;
  int bad = 0;
  int cyc = 0;

  always #5 clk = ~clk;

  vfd_grid_sequencer #(
    .GRID_COUNT(GC), .GRID_PERIOD(GP), .LAT_WIDTH(LW), .BLK_TAIL(BT), .BITS_PER_GRID(BPG)
  ) dut (
    .CLK(clk), .RST(rst), .EN(en), .HOST_BUSY(busy),
    .GN(gn), .BLK(blk), .LAT(lat), .SCE(sce), .FRAME_SYNC(fs), .SKIP_CNT(skip_cnt)
  );

  // Short-period instance used only for the skip counter saturation run.
  vfd_grid_sequencer #(
    .GRID_COUNT(GC), .GRID_PERIOD(SGP), .LAT_WIDTH(2), .BLK_TAIL(1), .BITS_PER_GRID(8)
  ) dut_sat (
    .CLK(clk), .RST(rst), .EN(s_en), .HOST_BUSY(s_busy),
    .GN(s_gn), .BLK(s_blk), .LAT(s_lat), .SCE(s_sce), .FRAME_SYNC(s_fs), .SKIP_CNT(s_skip_cnt)
  );

  // Reference model: tracks when the current period started and derives outputs from the offset.
  bit         m_run = 0;
  bit         m_skip = 0;
  int         m_t = 0;
  int         m_gn = 0;
  int         m_skipcnt = 0;
  int         m_ofs;
  bit         m_active;
  logic [17:0] exp_vec;

  always @(posedge clk) begin
    cyc++;
    if (rst) begin
      m_run = 0;
      m_gn = 0;
      m_skipcnt = 0;
    end else if (m_run && (cyc - m_t == GP) && !en) begin
      m_run = 0;
    end else if ((!m_run && en) || (m_run && (cyc - m_t == GP))) begin
      m_run = 1;
      m_t = cyc;
      m_skip = busy;
      if (busy && m_skipcnt < 255) m_skipcnt++;
    end
    m_ofs = cyc - m_t;
    m_active = m_run && !m_skip;
    if (m_active && m_ofs == SHIFT_OFS) m_gn = (m_gn == GC || m_gn == 0) ? 1 : m_gn + 1;
    exp_vec = {6'(m_gn),
               m_active && m_ofs <= LW + BT,
               m_active && m_ofs >= 1 && m_ofs <= LW,
               m_active && m_ofs >= SHIFT_OFS && m_ofs < SHIFT_OFS + BPG,
               m_active && m_ofs == SHIFT_OFS && m_gn == 1,
               8'(m_skipcnt)};
  end

  wire [17:0] dut_vec = {gn, blk, lat, sce, fs, skip_cnt};

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; en = 1'b0; busy = 1'b0; s_en = 1'b0; s_busy = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    en = 1'b1; busy = 1'b1;
    repeat (20) @(negedge clk);
    do_reset();
    total++; if (gn !== 6'd0) begin bad++; $display("[TB] FAIL reset_gn got=%0d want=0", gn); end
    total++; if (blk !== 1'b0) begin bad++; $display("[TB] FAIL reset_blk got=%b want=0", blk); end
    total++; if (lat !== 1'b0) begin bad++; $display("[TB] FAIL reset_lat got=%b want=0", lat); end
    total++; if (sce !== 1'b0) begin bad++; $display("[TB] FAIL reset_sce got=%b want=0", sce); end
    total++; if (fs !== 1'b0) begin bad++; $display("[TB] FAIL reset_fs got=%b want=0", fs); end
    total++; if (skip_cnt !== 8'd0) begin bad++; $display("[TB] FAIL reset_skip got=%0d want=0", skip_cnt); end
    repeat (5) @(negedge clk);
    total++;
    if (dut_vec !== 18'd0) begin bad++; $display("[TB] FAIL idle_hold got=%h want=0", dut_vec); end
  endtask

  task automatic test_first_period();
    int e;
    int p;
    logic [4:0] want;
    do_reset();
    en = 1'b1;
    e = cyc;
    for (int c = 1; c <= 402; c++) begin
      @(negedge clk);
      p = (c - 1) % GP;
      want = {(c >= 8) ? 1'b1 : 1'b0, p <= 6, p >= 1 && p <= 5, p >= 7 && p <= 294, c == 8};
      total++;
      if ({gn == 6'd1, blk, lat, sce, fs} !== want || (c < 8 && gn !== 6'd0)) begin
        bad++;
        $display("[TB] FAIL first_period cycle=%0d got gn=%0d blk/lat/sce/fs=%b%b%b%b want=%b",
                 cyc - e + 10, gn, blk, lat, sce, fs, want);
      end
    end
  endtask

  task automatic test_nine_periods();
    int gn_q[$];
    int w_q[$];
    int exp_seq[9] = '{1, 2, 3, 4, 1, 2, 3, 4, 1};
    int run_len = 0;
    int fs_cnt = 0;
    logic prev_sce = 1'b0;
    do_reset();
    en = 1'b1;
    for (int c = 1; c <= 3500; c++) begin
      @(negedge clk);
      total++;
      if (dut_vec !== exp_vec) begin
        bad++; $display("[TB] FAIL nine_model cycle=%0d got=%h want=%h", c, dut_vec, exp_vec);
      end
      if (sce && !prev_sce) gn_q.push_back(int'(gn));
      if (sce) run_len++;
      if (!sce && prev_sce) begin w_q.push_back(run_len); run_len = 0; end
      if (fs) fs_cnt++;
      prev_sce = sce;
    end
    total++;
    if (gn_q.size() != 9) begin bad++; $display("[TB] FAIL nine_count got=%0d want=9", gn_q.size()); end
    for (int i = 0; i < 9; i++) begin
      total++;
      if (((i < gn_q.size()) ? gn_q[i] : -1) != exp_seq[i]) begin
        bad++; $display("[TB] FAIL nine_gn idx=%0d got=%0d want=%0d", i, (i < gn_q.size()) ? gn_q[i] : -1, exp_seq[i]);
      end
      total++;
      if (((i < w_q.size()) ? w_q[i] : -1) != BPG) begin
        bad++; $display("[TB] FAIL nine_sce_width idx=%0d got=%0d want=%0d", i, (i < w_q.size()) ? w_q[i] : -1, BPG);
      end
    end
    total++;
    if (fs_cnt != 3) begin bad++; $display("[TB] FAIL nine_frame_sync got=%0d want=3", fs_cnt); end
  endtask

  task automatic test_skip();
    bit activity = 0;
    do_reset();
    en = 1'b1;
    for (int c = 1; c <= 1300; c++) begin
      @(negedge clk);
      total++;
      if (dut_vec !== exp_vec) begin
        bad++; $display("[TB] FAIL skip_model cycle=%0d got=%h want=%h", c, dut_vec, exp_vec);
      end
      if (c >= 801 && c <= 1200 && (blk || lat || sce)) activity = 1;
      if (c == 1000) begin
        total++;
        if (gn !== 6'd2 || skip_cnt !== 8'd1) begin
          bad++; $display("[TB] FAIL skip_hold got gn=%0d skip=%0d want gn=2 skip=1", gn, skip_cnt);
        end
      end
      if (c == 1208) begin
        total++;
        if (gn !== 6'd3 || sce !== 1'b1) begin
          bad++; $display("[TB] FAIL skip_resume got gn=%0d sce=%b want gn=3 sce=1", gn, sce);
        end
      end
      busy = (c >= 795 && c <= 805);
    end
    total++;
    if (activity) begin bad++; $display("[TB] FAIL skip_quiet got activity=1 want 0"); end
  endtask

  task automatic test_reset_in_latch();
    do_reset();
    en = 1'b1;
    for (int c = 1; c <= 20; c++) begin
      @(negedge clk);
      total++;
      if (dut_vec !== exp_vec) begin
        bad++; $display("[TB] FAIL rstlatch_model cycle=%0d got=%h want=%h", c, dut_vec, exp_vec);
      end
      if (c == 3) begin
        total++;
        if (lat !== 1'b1) begin bad++; $display("[TB] FAIL rstlatch_in_latch got lat=%b want=1", lat); end
      end
      if (c == 4) begin
        total++;
        if ({gn, blk, lat, sce} !== 9'd0) begin
          bad++; $display("[TB] FAIL rstlatch_cleared got gn=%0d blk=%b lat=%b sce=%b want all 0", gn, blk, lat, sce);
        end
      end
      if (c == 5) begin
        total++;
        if (blk !== 1'b1) begin bad++; $display("[TB] FAIL rstlatch_restart got blk=%b want=1", blk); end
      end
      if (c == 12) begin
        total++;
        if (gn !== 6'd1 || fs !== 1'b1) begin
          bad++; $display("[TB] FAIL rstlatch_gn got gn=%0d fs=%b want gn=1 fs=1", gn, fs);
        end
      end
      rst = (c == 3);
    end
  endtask

  task automatic test_en_deassert();
    int sce_cnt = 0;
    int late_blk = 0;
    do_reset();
    en = 1'b1;
    for (int c = 1; c <= 1000; c++) begin
      @(negedge clk);
      total++;
      if (dut_vec !== exp_vec) begin
        bad++; $display("[TB] FAIL endis_model cycle=%0d got=%h want=%h", c, dut_vec, exp_vec);
      end
      if (sce) sce_cnt++;
      if (c > 300 && blk) late_blk++;
      if (c == 150) en = 1'b0;
    end
    total++;
    if (sce_cnt != BPG) begin bad++; $display("[TB] FAIL endis_sce got=%0d want=%0d", sce_cnt, BPG); end
    total++;
    if (late_blk != 0) begin bad++; $display("[TB] FAIL endis_blk got=%0d want=0", late_blk); end
    total++;
    if (gn !== 6'd1) begin bad++; $display("[TB] FAIL endis_gn got=%0d want=1", gn); end
  endtask

  task automatic test_random();
    do_reset();
    en = 1'b1;
    for (int c = 1; c <= 6000; c++) begin
      @(negedge clk);
      total++;
      if (dut_vec !== exp_vec) begin
        bad++; $display("[TB] FAIL random_model cycle=%0d got=%h want=%h", c, dut_vec, exp_vec);
      end
      if ($urandom_range(0, 499) == 0) en = ~en;
      if ($urandom_range(0, 29) == 0) busy = ~busy;
      rst = ($urandom_range(0, 2999) == 0);
    end
    rst = 1'b0;
  endtask

  task automatic test_saturation();
    int k;
    int want;
    bit activity = 0;
    do_reset();
    s_en = 1'b1;
    s_busy = 1'b1;
    for (int c = 1; c <= 300 * SGP; c++) begin
      @(negedge clk);
      if (s_blk || s_lat || s_sce) activity = 1;
      if ((c - 1) % SGP == 8) begin
        k = (c - 1) / SGP + 1;
        want = (k > 255) ? 255 : k;
        total++;
        if (int'(s_skip_cnt) != want) begin
          bad++; $display("[TB] FAIL sat_count period=%0d got=%0d want=%0d", k, s_skip_cnt, want);
        end
      end
    end
    total++;
    if (activity) begin bad++; $display("[TB] FAIL sat_quiet got activity=1 want 0"); end
    s_en = 1'b0;
    s_busy = 1'b0;
  endtask

  initial begin
    test_reset();
    test_first_period();
    test_nine_periods();
    test_skip();
    test_reset_in_latch();
    test_en_deassert();
    test_random();
    test_saturation();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
